lfsr65_check: RTL and testbench

LFSR65_CHECK -- requirements
Module: lfsr65_check

---
 rtl/lfsr65_pkg.sv | 29 ++
 rtl/lfsr65_expand.sv | 28 ++
 rtl/lfsr65_check.sv | 171 +++++++++++++++++
 tb/tb_lfsr65_check.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr65_pkg.sv
// lfsr65_pkg
// Shared constants and types for the 65-bit PRBS checker.
//   LfsrBits  : length of the generator state
//   TapLong   : long tap distance, x[i-65]
//   TapShort  : short tap distance, x[i-47]
//   chk_state_t : checker state encoding
//   popcount64  : number of set bits in a 64-bit vector
package lfsr65_pkg;

    localparam int LfsrBits = 65;
    localparam int TapLong  = 65;
    localparam int TapShort = 47;

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_t;

    function automatic logic [6:0] popcount64(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + {6'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/lfsr65_expand.sv
// lfsr65_expand
// Combinational expansion of the sequence x[i] = x[i-65] ^ x[i-47].
// Ports:
//   state : 65 consecutive sequence bits, bit 0 the oldest
//   seq   : state followed by the next DataBits sequence bits
//           (seq[64:0] = state, seq[k] = seq[k-65] ^ seq[k-47] above that)
module lfsr65_expand
    import lfsr65_pkg::*;
#(
    parameter int DataBits = 32
) (
    input  logic [LfsrBits-1:0]          state,
    output logic [DataBits+LfsrBits-1:0] seq
);

    logic [DataBits+LfsrBits-1:0] s;

    always_comb begin
        s = '0;
        s[LfsrBits-1:0] = state;
        for (int k = LfsrBits; k < DataBits + LfsrBits; k++) begin
            s[k] = s[k-TapLong] ^ s[k-TapShort];
        end
    end

    assign seq = s;

endmodule

// File: rtl/lfsr65_check.sv
// lfsr65_check
// Self-synchronising checker for the 65-bit PRBS x[i] = x[i-65] ^ x[i-47].
// The first ceil(65/DataBits) valid words seed the local generator; after
// that every valid word is compared against the generator's prediction.
//
// Optional build macro: LFSR65_CHECK_BITCOUNT_EN -- err_count accumulates
// the number of wrong bits per word instead of the number of wrong words.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   data_valid  : data carries a word this cycle
//   data        : received word, bit 0 is the oldest sequence bit
//   clear       : zero err_count and word_count
//   resync      : drop back to SEED immediately
//   locked      : checker is in LOCKED
//   err         : one-cycle pulse, one cycle after a mismatching word
//   err_count   : saturating error count
//   word_count  : saturating count of checked words
//
// state  | meaning
// SEED   | collecting received words into the history register
// CHECK  | predicting, counting consecutive clean words towards lock
// LOCKED | predicting, counting consecutive errored words towards unlock
module lfsr65_check
    import lfsr65_pkg::*;
#(
    parameter int DataBits   = 32,
    parameter int LockWords  = 4,
    parameter int UnlockErrs = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data_valid,
    input  logic [DataBits-1:0] data,
    input  logic                clear,
    input  logic                resync,
    output logic                locked,
    output logic                err,
    output logic [31:0]         err_count,
    output logic [47:0]         word_count
);

    localparam int SeedWords = (LfsrBits + DataBits - 1) / DataBits;

    chk_state_t state, state_next;

    logic [LfsrBits-1:0]          hist, hist_next;
    logic [LfsrBits-1:0]          lfsr, lfsr_next;
    logic [DataBits+LfsrBits-1:0] seq;
    logic [DataBits-1:0]          expected, diff;
    logic [3:0]                   seed_cnt;
    logic [7:0]                   run_cnt;
    logic                         take, checking, mismatch, seed_done;
    logic                         lock_hit, unlock_hit;
    logic [6:0]                   err_inc;
    logic [32:0]                  err_sum;
    logic                         seq_unused;

    // lfsr holds the 65 most recent sequence bits, so the next word is the
    // part of the expansion above the state, and the new state is the top
    // 65 bits of the expansion.
    lfsr65_expand #(.DataBits(DataBits)) u_expand (
        .state (lfsr),
        .seq   (seq)
    );

    assign expected   = seq[DataBits+LfsrBits-1:LfsrBits];
    assign lfsr_next  = seq[DataBits+LfsrBits-1:DataBits];
    assign seq_unused = ^seq[DataBits-1:0];
    assign hist_next  = {data, hist[LfsrBits-1:DataBits]};

    // resync discards a coincident word entirely
    assign take       = data_valid && !resync;
    assign checking   = take && (state != ST_SEED);
    assign diff       = data ^ expected;
    assign mismatch   = |diff;
    assign seed_done  = take && (state == ST_SEED) && (seed_cnt == 4'(SeedWords - 1));
    assign lock_hit   = (run_cnt == 8'(LockWords - 1));
    assign unlock_hit = (run_cnt == 8'(UnlockErrs - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_SEED;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (resync) begin
            state_next = ST_SEED;
        end else if (take) begin
            case (state)
                ST_SEED:   if (seed_done) state_next = ST_CHECK;
                ST_CHECK:  begin
                    if (mismatch)      state_next = ST_SEED;
                    else if (lock_hit) state_next = ST_LOCKED;
                end
                ST_LOCKED: if (mismatch && unlock_hit) state_next = ST_SEED;
                default:   state_next = ST_SEED;
            endcase
        end
    end

    always_comb begin
        locked = (state == ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist     <= '0;
            lfsr     <= '0;
            seed_cnt <= '0;
            run_cnt  <= '0;
            err      <= 1'b0;
        end else begin
            err <= checking && mismatch;
            if (resync) begin
                seed_cnt <= '0;
                run_cnt  <= '0;
            end else if (take) begin
                case (state)
                    ST_SEED: begin
                        hist <= hist_next;
                        if (seed_done) begin
                            seed_cnt <= '0;
                            run_cnt  <= '0;
                            lfsr     <= hist_next;
                        end else begin
                            seed_cnt <= seed_cnt + 4'd1;
                        end
                    end
                    ST_CHECK: begin
                        lfsr <= lfsr_next;
                        if (mismatch || lock_hit) run_cnt <= '0;
                        else                      run_cnt <= run_cnt + 8'd1;
                    end
                    default: begin
                        lfsr <= lfsr_next;
                        if (!mismatch || unlock_hit) run_cnt <= '0;
                        else                         run_cnt <= run_cnt + 8'd1;
                    end
                endcase
            end
        end
    end

`ifdef LFSR65_CHECK_BITCOUNT_EN
    assign err_inc = popcount64(64'(diff));
`else
    assign err_inc = 7'd1;
`endif

    assign err_sum = {1'b0, err_count} + 33'(err_inc);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            err_count  <= '0;
            word_count <= '0;
        end else begin
            if (checking && mismatch) begin
                err_count <= err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
            end
            if (checking && (word_count != 48'hFFFF_FFFF_FFFF)) begin
                word_count <= word_count + 48'd1;
            end
        end
    end

endmodule

// File: tb/tb_lfsr65_check.sv
// tb_lfsr65_check
// Directed bench for lfsr65_check with DataBits=32, LockWords=4,
// UnlockErrs=3. Stimulus words come from a software copy of the generator
// seeded with 65'h15555555555555555; expected outputs are hand-derived
// constants (lock after 3 seed + 4 clean words, etc.).
module tb_lfsr65_check;

    localparam logic [64:0] GenSeed = 65'h1_5555_5555_5555_5555;
    localparam int          StreamBits = 8192;

`ifdef LFSR65_CHECK_BITCOUNT_EN
    localparam logic [31:0] IncFlip2 = 32'd2;
    localparam logic [31:0] IncFull  = 32'd32;
`else
    localparam logic [31:0] IncFlip2 = 32'd1;
    localparam logic [31:0] IncFull  = 32'd1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_valid = 1'b0;
    logic [31:0] data = '0;
    logic        clear = 1'b0;
    logic        resync = 1'b0;
    logic        locked;
    logic        err;
    logic [31:0] err_count;
    logic [47:0] word_count;

    int checks = 0;
    int errors = 0;
    int err_hits = 0;
    int ptr = 0;
    logic stream [StreamBits];

    always #5 clk = ~clk;

    lfsr65_check #(.DataBits(32), .LockWords(4), .UnlockErrs(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .data       (data),
        .clear      (clear),
        .resync     (resync),
        .locked     (locked),
        .err        (err),
        .err_count  (err_count),
        .word_count (word_count)
    );

    task automatic next_word(output logic [31:0] w);
        for (int b = 0; b < 32; b++) w[b] = stream[ptr + b];
        ptr = ptr + 32;
    endtask

    // one valid cycle; outputs are sampled 1 ns after the edge that takes it
    task automatic send(input logic [31:0] w);
        data = w;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        if (err) err_hits++;
    endtask

    task automatic send_clean(input int n);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            next_word(w);
            send(w);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear = 1'b1;
        resync = 1'b1;
        data_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        clear = 1'b0;
        resync = 1'b0;
        data_valid = 1'b0;
        rst = 1'b0;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b expected 0", locked); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err); end
        checks++; if (err_count !== 32'd0) begin errors++; $display("FAIL reset_err_count: got %0h expected 0", err_count); end
        checks++; if (word_count !== 48'd0) begin errors++; $display("FAIL reset_word_count: got %0h expected 0", word_count); end
    endtask

    task automatic test_clean_lock();
        err_hits = 0;
        send_clean(6);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_after6: got %0b expected 0", locked); end
        send_clean(1);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_after7: got %0b expected 1", locked); end
        send_clean(3);
        checks++; if (word_count !== 48'd7) begin errors++; $display("FAIL lock_word_count: got %0d expected 7", word_count); end
        checks++; if (err_count !== 32'd0) begin errors++; $display("FAIL lock_err_count: got %0d expected 0", err_count); end
        checks++; if (err_hits !== 0) begin errors++; $display("FAIL lock_err_pulses: got %0d expected 0", err_hits); end
    endtask

    task automatic test_bit_flip();
        logic [31:0] w;
        logic [31:0] base;
        base = err_count;
        next_word(w);
        send(w ^ 32'h0000_0021);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL flip_err_pulse: got %0b expected 1", err); end
        send_clean(1);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL flip_err_drop: got %0b expected 0", err); end
        checks++; if (err_count !== base + IncFlip2) begin errors++; $display("FAIL flip_err_count: got %0d expected %0d", err_count, base + IncFlip2); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL flip_locked: got %0b expected 1", locked); end
    endtask

    task automatic test_unlock();
        logic [31:0] w;
        logic [31:0] base;
        base = err_count;
        next_word(w);
        send(w ^ 32'hFFFF_FFFF);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL unlock_after1: got %0b expected 1", locked); end
        next_word(w);
        send(w ^ 32'hFFFF_FFFF);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL unlock_after2: got %0b expected 1", locked); end
        next_word(w);
        send(w ^ 32'hFFFF_FFFF);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL unlock_after3: got %0b expected 0", locked); end
        checks++; if (err_count !== base + 3 * IncFull) begin errors++; $display("FAIL unlock_err_count: got %0d expected %0d", err_count, base + 3 * IncFull); end
        send_clean(6);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL relock_after6: got %0b expected 0", locked); end
        send_clean(1);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock_after7: got %0b expected 1", locked); end
    endtask

    task automatic test_check_error();
        logic [31:0] w;
        do_reset();
        send_clean(4);
        next_word(w);
        send(w ^ 32'h0000_0001);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL chkerr_err: got %0b expected 1", err); end
        checks++; if (word_count !== 48'd2) begin errors++; $display("FAIL chkerr_word_count: got %0d expected 2", word_count); end
        send_clean(6);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL chkerr_locked: got %0b expected 0", locked); end
        checks++; if (word_count !== 48'd5) begin errors++; $display("FAIL chkerr_word_count2: got %0d expected 5", word_count); end
        send_clean(1);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL chkerr_relock: got %0b expected 1", locked); end
    endtask

    task automatic test_clear();
        logic [31:0] w;
        next_word(w);
        clear = 1'b1;
        send(w ^ 32'h8000_0000);
        clear = 1'b0;
        checks++; if (err_count !== 32'd0) begin errors++; $display("FAIL clear_err_count: got %0d expected 0", err_count); end
        checks++; if (word_count !== 48'd0) begin errors++; $display("FAIL clear_word_count: got %0d expected 0", word_count); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL clear_err: got %0b expected 1", err); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL clear_locked: got %0b expected 1", locked); end
        send_clean(1);
        checks++; if (word_count !== 48'd1) begin errors++; $display("FAIL clear_word_count2: got %0d expected 1", word_count); end
    endtask

    task automatic test_resync();
        logic [31:0] w;
        next_word(w);
        resync = 1'b1;
        send(w);
        resync = 1'b0;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL resync_locked: got %0b expected 0", locked); end
        checks++; if (word_count !== 48'd1) begin errors++; $display("FAIL resync_word_count: got %0d expected 1", word_count); end
        send_clean(6);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL resync_after6: got %0b expected 0", locked); end
        send_clean(1);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL resync_relock: got %0b expected 1", locked); end
        checks++; if (word_count !== 48'd5) begin errors++; $display("FAIL resync_word_count2: got %0d expected 5", word_count); end
    endtask

    task automatic test_reset_locked();
        rst = 1'b1;
        clear = 1'b1;
        resync = 1'b1;
        send(32'hDEAD_BEEF);
        rst = 1'b0;
        clear = 1'b0;
        resync = 1'b0;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rstlk_locked: got %0b expected 0", locked); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rstlk_err: got %0b expected 0", err); end
        checks++; if (err_count !== 32'd0) begin errors++; $display("FAIL rstlk_err_count: got %0d expected 0", err_count); end
        checks++; if (word_count !== 48'd0) begin errors++; $display("FAIL rstlk_word_count: got %0d expected 0", word_count); end
        // reset partway through seeding: the two words taken so far are lost
        send_clean(2);
        do_reset();
        ptr = ptr + 1000;
        send_clean(6);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rstseed_after6: got %0b expected 0", locked); end
        send_clean(1);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rstseed_relock: got %0b expected 1", locked); end
    endtask

    task automatic test_saturate();
        logic [31:0] w;
        force dut.err_count = 32'hFFFF_FFFE;
        #1;
        release dut.err_count;
        #1;
        next_word(w);
        send(w ^ 32'h0000_0003);
        checks++; if (err_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_first: got %0h expected ffffffff", err_count); end
        next_word(w);
        send(w ^ 32'h0000_0003);
        checks++; if (err_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold: got %0h expected ffffffff", err_count); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL sat_locked: got %0b expected 1", locked); end
        send_clean(1);
    endtask

    initial begin
        for (int i = 0; i < 65; i++) stream[i] = GenSeed[i];
        for (int i = 65; i < StreamBits; i++) stream[i] = stream[i-65] ^ stream[i-47];

        test_reset();
        test_clean_lock();
        test_bit_flip();
        test_unlock();
        test_check_error();
        test_clear();
        test_resync();
        test_reset_locked();
        test_saturate();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
